// File: rtl/mem_resp_bram_if.sv
// Single-word rd/wr request bus with busy handshake between an initiator and a memory responder.
// Latency: set by the responder; backpressure: o_busy high while an access is in flight.
interface mem_resp_bram_if;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [3:0]  i_ctrl;
    logic [31:0] o_data;
    logic        o_busy;

    modport master (
        output i_rd_en, i_wr_en, i_addr, i_data, i_ctrl,
        input  o_data, o_busy
    );

    modport slave (
        input  i_rd_en, i_wr_en, i_addr, i_data, i_ctrl,
        output o_data, o_busy
    );
endinterface

// File: rtl/mem_resp_bram.sv
// BRAM-backed responder: byte-masked word read/write, optional clear of all words after reset.
// Latency: o_busy high LATENCY cycles per access; backpressure: requests seen while busy are dropped, not queued.
module mem_resp_bram #(
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_x,
    mem_resp_bram_if.slave   bus,
    output logic             w_init_done,
    output logic [1:0]       o_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW:0]     r_clr_cnt;
    logic            r_pend;
    logic            r_is_wr;
    logic            r_busy;
    logic            r_init_done;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdat;
    logic [31:0]     r_rdata;
    logic [3:0]      r_be;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_clr_done;
    logic            w_latch;
    logic            w_start;
    logic            w_complete;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_idx;
    logic [31:0]     w_mem_wdat;
    logic [3:0]      w_mem_be;
    logic            w_unused_addr;

    assign w_req         = bus.i_rd_en | bus.i_wr_en;
    assign w_clr_done    = !CLEAR_ON_RESET || (r_clr_cnt == (AW+1)'(DEPTH));
    assign w_unused_addr = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0]};

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) r_state <= ST_INIT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_idx    = r_idx;
        w_mem_wdat   = r_wdat;
        w_mem_be     = r_be;
        case (r_state)
            ST_INIT: begin
                // First request seen during clear is captured; busy then bridges into ACCESS without a gap.
                w_latch = w_req && !r_pend;
                if (!w_clr_done) begin
                    w_mem_we   = 1'b1;
                    w_mem_idx  = r_clr_cnt[AW-1:0];
                    w_mem_wdat = 32'd0;
                    w_mem_be   = 4'hF;
                end else if (r_pend || w_req) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_req) begin
                    w_latch      = 1'b1;
                    w_start      = 1'b1;
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == CW'(1)) begin
                    w_complete   = 1'b1;
                    w_mem_we     = r_is_wr;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_clr_cnt   <= '0;
            r_pend      <= 1'b0;
            r_is_wr     <= 1'b0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_idx       <= '0;
            r_wdat      <= 32'd0;
            r_be        <= 4'd0;
            r_cnt       <= '0;
            r_rdata     <= 32'd0;
        end else begin
            if (r_state == ST_INIT && !w_clr_done) r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_state == ST_INIT && w_clr_done)  r_init_done <= 1'b1;
            if (w_latch) begin
                r_idx   <= bus.i_addr[AW+1:2];
                r_wdat  <= bus.i_data;
                r_be    <= bus.i_ctrl;
                r_is_wr <= bus.i_wr_en;
                r_busy  <= 1'b1;
                r_pend  <= 1'b1;
            end
            if (w_start) begin
                r_pend <= 1'b0;
                r_cnt  <= CW'(LATENCY);
            end
            if (r_state == ST_ACCESS && !w_complete) r_cnt <= r_cnt - 1'b1;
            if (w_complete) begin
                r_busy <= 1'b0;
                if (!r_is_wr) r_rdata <= r_mem[r_idx];
            end
        end
    end

    // No reset on the array so it maps onto block RAM; reset safety comes from the FSM gating w_mem_we.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdat[8*b +: 8];
            end
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_data  = r_rdata;
    assign w_init_done = r_init_done;
    assign o_state     = r_state;
endmodule

// File: tb/tb_mem_resp_bram.sv
// Directed bench: instance A (DEPTH 16, LATENCY 4, clear on reset), instance B (DEPTH 16, LATENCY 1, no clear).
module tb_mem_resp_bram;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic init_done_a, init_done_b;
    logic [1:0] state_a, state_b;
    int n_tests = 0;
    int n_fail  = 0;

    mem_resp_bram_if bus_a ();
    mem_resp_bram_if bus_b ();

    mem_resp_bram #(.DEPTH(16), .LATENCY(4), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_x(rst_a), .bus(bus_a), .w_init_done(init_done_a), .o_state(state_a));
    mem_resp_bram #(.DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .rst_x(rst_b), .bus(bus_b), .w_init_done(init_done_b), .o_state(state_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts consecutive busy cycles on A (sampled at negedge), dropping the request once busy is seen.
    task automatic wait_busy_a(output int nbusy);
        nbusy = 0;
        @(negedge clk);
        bus_a.i_rd_en = 1'b0;
        bus_a.i_wr_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!bus_a.o_busy) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] ctrl,
                            output int nbusy, output logic [31:0] rdata);
        @(negedge clk);
        bus_a.i_rd_en = rd;
        bus_a.i_wr_en = wr;
        bus_a.i_addr  = addr;
        bus_a.i_data  = data;
        bus_a.i_ctrl  = ctrl;
        wait_busy_a(nbusy);
        rdata = bus_a.o_data;
    endtask

    task automatic wait_init_a(output int ncyc);
        ncyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (init_done_a) begin
                ncyc = i;
                break;
            end
        end
    endtask

    initial begin
        int nb;
        int ncyc;
        logic [31:0] rd;

        bus_a.i_rd_en = 0; bus_a.i_wr_en = 0; bus_a.i_addr = 0; bus_a.i_data = 0; bus_a.i_ctrl = 0;
        bus_b.i_rd_en = 0; bus_b.i_wr_en = 0; bus_b.i_addr = 0; bus_b.i_data = 0; bus_b.i_ctrl = 0;

        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, bus_a.o_busy}, 32'd0);
        check("rst_data",  bus_a.o_data, 32'd0);
        check("rst_done",  {31'd0, init_done_a}, 32'd0);
        check("rst_state", {30'd0, state_a}, 32'd0);

        rst_a = 1'b1;
        wait_init_a(ncyc);
        check("init_cycles", ncyc, 17);
        @(negedge clk);
        check("idle_state", {30'd0, state_a}, 32'd1);

        access_a(1, 0, 32'h0, 0, 4'hF, nb, rd);
        check("clr_rd_0", rd, 32'h0);
        access_a(1, 0, 32'h3C, 0, 4'hF, nb, rd);
        check("clr_rd_3c", rd, 32'h0);

        access_a(0, 1, 32'h40, 32'h12345678, 4'hF, nb, rd);
        check("wr_busy_len", nb, 4);
        access_a(1, 0, 32'h40, 0, 4'hF, nb, rd);
        check("rd_busy_len", nb, 4);
        check("rd_40", rd, 32'h12345678);
        access_a(0, 1, 32'h4, 32'h55555555, 4'hF, nb, rd);
        check("wr_keeps_odata", rd, 32'h12345678);

        access_a(0, 1, 32'h40, 32'hAABBCCDD, 4'b0101, nb, rd);
        access_a(1, 0, 32'h40, 0, 4'hF, nb, rd);
        check("mask_0101", rd, 32'h12BB56DD);
        access_a(0, 1, 32'h40, 32'hFFFFFFFF, 4'b0000, nb, rd);
        check("mask0_busy", nb, 4);
        access_a(1, 0, 32'h40, 0, 4'hF, nb, rd);
        check("mask_0000", rd, 32'h12BB56DD);

        access_a(1, 1, 32'h8, 32'h0BADF00D, 4'hF, nb, rd);
        check("rdwr_odata", rd, 32'h12BB56DD);
        access_a(1, 0, 32'h8, 0, 4'h0, nb, rd);
        check("rdwr_is_wr", rd, 32'h0BADF00D);

        // Request raised together with reset release, so it arrives during the clear phase.
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        bus_a.i_wr_en = 1'b1;
        bus_a.i_addr  = 32'h10;
        bus_a.i_data  = 32'hCAFEF00D;
        bus_a.i_ctrl  = 4'hF;
        wait_busy_a(nb);
        check("init_req_busy", nb, 20);
        check("init_req_done", {31'd0, init_done_a}, 32'd1);
        access_a(1, 0, 32'h10, 0, 4'hF, nb, rd);
        check("init_req_wr", rd, 32'hCAFEF00D);
        access_a(1, 0, 32'h8, 0, 4'hF, nb, rd);
        check("reclear_8", rd, 32'h0);

        @(negedge clk);
        bus_a.i_wr_en = 1'b1;
        bus_a.i_addr  = 32'h14;
        bus_a.i_data  = 32'hDEADBEEF;
        @(negedge clk);
        bus_a.i_wr_en = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, bus_a.o_busy}, 32'd0);
        check("midrst_data",  bus_a.o_data, 32'd0);
        check("midrst_done",  {31'd0, init_done_a}, 32'd0);
        check("midrst_state", {30'd0, state_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        wait_init_a(ncyc);
        check("midrst_init", ncyc, 17);
        access_a(1, 0, 32'h14, 0, 4'hF, nb, rd);
        check("midrst_word", rd, 32'h0);

        // Instance B: one-cycle INIT, LATENCY 1.
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_init_done", {31'd0, init_done_b}, 32'd1);
        check("b_state", {30'd0, state_b}, 32'd1);
        bus_b.i_wr_en = 1'b1;
        bus_b.i_addr  = 32'h8;
        bus_b.i_data  = 32'h11223344;
        bus_b.i_ctrl  = 4'hF;
        @(negedge clk);
        check("b_wr_busy", {31'd0, bus_b.o_busy}, 32'd1);
        bus_b.i_wr_en = 1'b0;
        @(negedge clk);
        check("b_wr_end", {31'd0, bus_b.o_busy}, 32'd0);

        bus_b.i_rd_en = 1'b1;
        nb = 0;
        @(negedge clk);
        if (bus_b.o_busy) nb++;
        @(negedge clk);
        bus_b.i_rd_en = 1'b0;
        if (bus_b.o_busy) nb++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_b.o_busy) nb++;
        end
        check("b_rd_one_access", nb, 1);
        check("b_rd_data", bus_b.o_data, 32'h11223344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
